// File: rtl/axi_b_pkg.sv
// rtl/axi_b_pkg.sv - shared AXI B-channel encodings and helpers
package axi_b_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // SLVERR and DECERR both carry resp[1]=1
   function automatic logic is_err_resp(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/axi_fifo_core.sv
// rtl/axi_fifo_core.sv - circular FIFO of any depth with optional fall-through bypass
module axi_fifo_core #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DEPTH        = 8,
   parameter bit          FALL_THROUGH = 1'b0,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  in_ready_o,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  out_ready_i,
   output logic [CNT_W-1:0]      usage_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  empty, bypass, push, pop, wr_en, rd_en;

   assign empty      = (count_q == '0);
   assign in_ready_o = (count_q != CNT_W'(DEPTH));
   assign bypass     = FALL_THROUGH && empty;

   assign out_valid_o = bypass ? in_valid_i : !empty;
   assign out_data_o  = bypass ? in_data_i  : mem_q[rd_ptr_q];

   assign push  = in_valid_i && in_ready_o;
   assign pop   = out_valid_o && out_ready_i;
   // a bypassed beat consumed in the same cycle never touches storage
   assign wr_en = push && !(bypass && out_ready_i);
   assign rd_en = pop && !bypass;

   assign usage_o = count_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (wr_en && !rd_en) begin
         count_d = count_q + CNT_W'(1);
      end else if (!wr_en && rd_en) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

endmodule

// File: rtl/axi_b_buffer_stat.sv
// rtl/axi_b_buffer_stat.sv - AXI B-channel buffer with occupancy and error-response statistics
module axi_b_buffer_stat #(
   parameter int unsigned ID_WIDTH      = 4,
   parameter int unsigned USER_WIDTH    = 6,
   parameter int unsigned BUFFER_DEPTH  = 8,
   parameter bit          FALL_THROUGH  = 1'b0,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             test_en_i,
   input  logic                             slave_valid_i,
   input  logic [1:0]                       slave_resp_i,
   input  logic [ID_WIDTH-1:0]              slave_id_i,
   input  logic [USER_WIDTH-1:0]            slave_user_i,
   output logic                             slave_ready_o,
   output logic                             master_valid_o,
   output logic [1:0]                       master_resp_o,
   output logic [ID_WIDTH-1:0]              master_id_o,
   output logic [USER_WIDTH-1:0]            master_user_o,
   input  logic                             master_ready_i,
   output logic [$clog2(BUFFER_DEPTH+1)-1:0] usage_o,
   output logic [ERR_CNT_WIDTH-1:0]         err_cnt_o,
   output logic [ID_WIDTH-1:0]              last_err_id_o,
   input  logic                             err_clr_i
);

   import axi_b_pkg::*;

   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [USER_WIDTH-1:0] user;
      logic [1:0]            resp;
   } b_beat_t;

   b_beat_t in_beat, out_beat;
   logic    unused_test_en;
   logic    err_pop;

   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic [ID_WIDTH-1:0]      last_err_id_q, last_err_id_d;

   assign unused_test_en = test_en_i;

   assign in_beat = '{id: slave_id_i, user: slave_user_i, resp: slave_resp_i};

   axi_fifo_core #(
      .DATA_WIDTH   ($bits(b_beat_t)),
      .DEPTH        (BUFFER_DEPTH),
      .FALL_THROUGH (FALL_THROUGH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .in_valid_i  (slave_valid_i),
      .in_data_i   (in_beat),
      .in_ready_o  (slave_ready_o),
      .out_valid_o (master_valid_o),
      .out_data_o  (out_beat),
      .out_ready_i (master_ready_i),
      .usage_o     (usage_o)
   );

   assign master_id_o   = out_beat.id;
   assign master_user_o = out_beat.user;
   assign master_resp_o = out_beat.resp;

   assign err_pop = master_valid_o && master_ready_i && is_err_resp(master_resp_o);

   // clear takes priority, then the same-cycle error is counted on top of it
   always_comb begin
      err_cnt_d     = err_cnt_q;
      last_err_id_d = last_err_id_q;
      if (err_clr_i) begin
         err_cnt_d = err_pop ? ERR_CNT_WIDTH'(1) : '0;
      end else if (err_pop && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
      if (err_pop) begin
         last_err_id_d = master_id_o;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_q     <= '0;
         last_err_id_q <= '0;
      end else begin
         err_cnt_q     <= err_cnt_d;
         last_err_id_q <= last_err_id_d;
      end
   end

   assign err_cnt_o     = err_cnt_q;
   assign last_err_id_o = last_err_id_q;

endmodule

// File: tb/tb_axi_b_buffer_stat.sv
// tb/tb_axi_b_buffer_stat.sv - directed self-checking bench for axi_b_buffer_stat
module tb_axi_b_buffer_stat;

   import axi_b_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // instance a: registered mode, instance b: fall-through mode
   logic       a_sv = 0, a_sr, a_mv, a_mr = 0, a_clr = 0;
   logic [1:0] a_resp = 0, a_mresp, a_usage, a_err;
   logic [3:0] a_id = 0, a_mid, a_lid;
   logic [5:0] a_user = 0, a_muser;

   logic       b_sv = 0, b_sr, b_mv, b_mr = 0, b_clr = 0;
   logic [1:0] b_resp = 0, b_mresp, b_usage, b_err;
   logic [3:0] b_id = 0, b_mid, b_lid;
   logic [5:0] b_user = 0, b_muser;

   axi_b_buffer_stat #(.ID_WIDTH(4), .USER_WIDTH(6), .BUFFER_DEPTH(3),
                       .FALL_THROUGH(1'b0), .ERR_CNT_WIDTH(2)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
      .slave_valid_i(a_sv), .slave_resp_i(a_resp), .slave_id_i(a_id), .slave_user_i(a_user),
      .slave_ready_o(a_sr), .master_valid_o(a_mv), .master_resp_o(a_mresp),
      .master_id_o(a_mid), .master_user_o(a_muser), .master_ready_i(a_mr),
      .usage_o(a_usage), .err_cnt_o(a_err), .last_err_id_o(a_lid), .err_clr_i(a_clr));

   axi_b_buffer_stat #(.ID_WIDTH(4), .USER_WIDTH(6), .BUFFER_DEPTH(3),
                       .FALL_THROUGH(1'b1), .ERR_CNT_WIDTH(2)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
      .slave_valid_i(b_sv), .slave_resp_i(b_resp), .slave_id_i(b_id), .slave_user_i(b_user),
      .slave_ready_o(b_sr), .master_valid_o(b_mv), .master_resp_o(b_mresp),
      .master_id_o(b_mid), .master_user_o(b_muser), .master_ready_i(b_mr),
      .usage_o(b_usage), .err_cnt_o(b_err), .last_err_id_o(b_lid), .err_clr_i(b_clr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] err_resp [6];
   logic [3:0] err_id   [6];
   logic [1:0] exp_cnt  [6];
   logic [3:0] exp_lid  [6];

   initial begin
      err_resp = '{RESP_OKAY, RESP_SLVERR, RESP_DECERR, RESP_EXOKAY, RESP_SLVERR, RESP_SLVERR};
      err_id   = '{4'd1, 4'd7, 4'd9, 4'd2, 4'd3, 4'd4};
      exp_cnt  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
      exp_lid  = '{4'd0, 4'd7, 4'd9, 4'd9, 4'd3, 4'd4};

      // reset state
      #1;
      chk("rst_usage", a_usage, 0);
      chk("rst_ready", a_sr, 1);
      chk("rst_valid", a_mv, 0);
      chk("rst_err", a_err, 0);
      chk("rst_lid", a_lid, 0);
      b_sv = 1; b_id = 4'd3;
      #1;
      chk("rst_ft_valid", b_mv, 1);
      b_sv = 0;
      #1;
      chk("rst_ft_valid_lo", b_mv, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // fill depth-3 buffer, 4th beat refused, then drain in order
      for (int i = 1; i <= 3; i++) begin
         a_sv = 1; a_id = 4'(i);
         tick();
         chk("fill_usage", a_usage, i);
      end
      chk("full_ready", a_sr, 0);
      a_id = 4'd4;
      tick();
      chk("full_no_push", a_usage, 3);
      a_sv = 0; a_mr = 1;
      for (int i = 1; i <= 3; i++) begin
         #1;
         chk("drain_valid", a_mv, 1);
         chk("drain_id", a_mid, i);
         tick();
      end
      chk("drained_valid", a_mv, 0);
      chk("drained_usage", a_usage, 0);

      // 10 back-to-back beats through a non-power-of-2 depth
      for (int k = 0; k < 10; k++) begin
         a_sv = 1; a_id = 4'(k + 1);
         #1;
         chk("stream_valid", a_mv, (k != 0));
         if (k != 0) chk("stream_id", a_mid, k);
         tick();
         chk("stream_usage", a_usage, 1);
      end
      a_sv = 0;
      #1;
      chk("stream_last_id", a_mid, 10);
      tick();
      chk("stream_end_usage", a_usage, 0);

      // full with simultaneous pop and push attempt
      a_mr = 0;
      for (int i = 1; i <= 3; i++) begin
         a_sv = 1; a_id = 4'(i);
         tick();
      end
      a_id = 4'd4; a_mr = 1;
      #1;
      chk("fullpop_ready", a_sr, 0);
      chk("fullpop_id", a_mid, 1);
      tick();
      chk("fullpop_usage", a_usage, 2);
      a_mr = 0;
      #1;
      chk("fullpop_ready_back", a_sr, 1);
      tick();
      chk("fullpop_push_usage", a_usage, 3);
      a_sv = 0; a_mr = 1;
      for (int i = 2; i <= 4; i++) begin
         #1;
         chk("fullpop_drain_id", a_mid, i);
         tick();
      end
      chk("fullpop_empty", a_usage, 0);

      // error statistics with a 2-bit saturating counter
      for (int j = 0; j < 6; j++) begin
         a_sv = 1; a_mr = 0; a_resp = err_resp[j]; a_id = err_id[j];
         tick();
         a_sv = 0; a_mr = 1;
         tick();
         chk("err_cnt", a_err, exp_cnt[j]);
         chk("err_lid", a_lid, exp_lid[j]);
      end
      a_mr = 0; a_clr = 1;
      tick();
      a_clr = 0;
      chk("clr_idle_cnt", a_err, 0);
      chk("clr_idle_lid", a_lid, 4);
      a_sv = 1; a_resp = RESP_SLVERR; a_id = 4'd6;
      tick();
      a_sv = 0; a_mr = 1; a_clr = 1;
      tick();
      a_clr = 0; a_mr = 0; a_resp = RESP_OKAY;
      chk("clr_err_cnt", a_err, 1);
      chk("clr_err_lid", a_lid, 6);

      // fall-through instance: bypass when ready, store when stalled
      b_sv = 1; b_id = 4'd5; b_mr = 1;
      #1;
      chk("ft_valid", b_mv, 1);
      chk("ft_id", b_mid, 5);
      tick();
      chk("ft_bypass_usage", b_usage, 0);
      b_mr = 0;
      #1;
      chk("ft_stall_valid", b_mv, 1);
      tick();
      b_sv = 0; b_id = 4'd0;
      #1;
      chk("ft_stored_usage", b_usage, 1);
      chk("ft_held_valid", b_mv, 1);
      chk("ft_held_id", b_mid, 5);
      tick();
      chk("ft_held_id2", b_mid, 5);
      b_mr = 1;
      tick();
      chk("ft_drain_usage", b_usage, 0);
      chk("ft_drain_valid", b_mv, 0);
      b_mr = 0;

      // asynchronous reset with two beats stored
      a_mr = 0;
      a_sv = 1; a_id = 4'd11;
      tick();
      a_id = 4'd12;
      tick();
      a_sv = 0;
      chk("pre_rst_usage", a_usage, 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_usage", a_usage, 0);
      chk("arst_valid", a_mv, 0);
      chk("arst_ready", a_sr, 1);
      chk("arst_err", a_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      a_mr = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_valid", a_mv, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
